// File: rtl/exp_lut_arbiter_if.sv
// Request/response bundle between the operator units, the exp-LUT arbiter and the mixer.
// The master side is the requesters plus mixer, and the slave side is the arbiter.
interface exp_lut_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*12-1:0] req_atten;
  logic [NREQ-1:0]    req_sign;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [11:0]        rsp_value;

  modport master (
    output req_valid, req_atten, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_value
  );

  modport slave (
    input  req_valid, req_atten, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_value
  );
endinterface

// File: rtl/exp_lut_arbiter.sv
// Round-robin time-sharing of one 256x10 exponent LUT between NREQ requesters.
// Stage 1 latches the granted request and drives the LUT index. Stage 2 rebuilds the signed linear amplitude.
module exp_lut_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  exp_lut_arbiter_if.slave      bus,
  output logic [7:0]            lut_idx,
  input  logic [9:0]            lut_value
);

  logic            advance;
  logic            found;
  logic            accept;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] ready;

  logic            s1_valid;
  logic [7:0]      s1_idx;
  logic [3:0]      s1_shift;
  logic            s1_sign;
  logic [IDW-1:0]  s1_id;

  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic [11:0]     out_value;

  logic [10:0]     mant;
  logic [10:0]     mag;
  logic [11:0]     signed_mag;

  // The whole pipeline freezes only when a finished sample is waiting on the mixer.
  assign advance = !(out_valid && !bus.rsp_ready);

  always_comb begin
    int cand;
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand[IDW-1:0];
      end
    end
  end

  assign accept = advance && found;

  always_comb begin
    ready = '0;
    if (accept) begin
      ready[grant] = 1'b1;
    end
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= IDW'(NREQ - 1);
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_shift <= '0;
      s1_sign  <= 1'b0;
      s1_id    <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        rr_ptr   <= grant;
        s1_idx   <= bus.req_atten[int'(grant)*12 +: 8];
        s1_shift <= bus.req_atten[int'(grant)*12 + 8 +: 4];
        s1_sign  <= bus.req_sign[grant];
        s1_id    <= grant;
      end
    end
  end

  assign lut_idx = s1_idx;

  // Implicit leading one on the LUT mantissa. Shifts past the mantissa width flush to zero.
  always_comb begin
    mant = {1'b1, lut_value};
    mag  = (s1_shift >= 4'd11) ? 11'd0 : (mant >> s1_shift);
    signed_mag = s1_sign ? (12'd0 - {1'b0, mag}) : {1'b0, mag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_value <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id    <= s1_id;
        out_value <= signed_mag;
      end
    end
  end

  assign bus.rsp_valid = out_valid;
  assign bus.rsp_id    = out_id;
  assign bus.rsp_value = out_value;

  ready_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(ready));

  stall_holds : assert property (@(posedge clk) disable iff (reset)
    (out_valid && !bus.rsp_ready) |=> (out_valid && $stable(out_value) && $stable(out_id)));

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Directed vectors plus a cycle-level reference model of the arbiter pipeline.
// A behavioural exp table stands in for the external LUT.
module tb_exp_lut_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic       clk;
  logic       reset;
  logic [7:0] lut_idx;
  logic [9:0] lut_value;
  logic [9:0] lut [256];

  exp_lut_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  exp_lut_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .lut_idx   (lut_idx),
    .lut_value (lut_value)
  );

  assign lut_value = lut[lut_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          id;
    logic [11:0] atten;
    logic        sign;
    logic [11:0] exp_value;
  } vec_t;

  vec_t vecs [8];

  // Model state
  int          m_rr;
  bit          m_s1_v;
  int          m_s1_id;
  logic [11:0] m_s1_val;
  logic [7:0]  m_s1_idx;
  bit          m_out_v;
  int          m_out_id;
  logic [11:0] m_out_val;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] expectVal(input logic [11:0] atten, input logic sign);
    int m;
    int s;
    int mag;
    int v;
    m   = 1024 + int'(lut[atten[7:0]]);
    s   = int'(atten[11:8]);
    mag = (s >= 11) ? 0 : (m / (1 << s));
    v   = sign ? -mag : mag;
    return 12'(v);
  endfunction

  // Compares DUT outputs against the model, then steps the model across the coming edge.
  task automatic monitor();
    logic [NREQ-1:0] exp_ready;
    logic [11:0]     a;
    int              g;
    int              c;
    bit              fnd;
    bit              adv;
    if (reset) begin
      m_rr = NREQ - 1; m_s1_v = 0; m_out_v = 0;
      return;
    end
    adv = !(m_out_v && !bus.rsp_ready);
    fnd = 0; g = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_rr + k) % NREQ;
      if (!fnd && bus.req_valid[c]) begin fnd = 1; g = c; end
    end
    exp_ready = '0;
    if (adv && fnd) exp_ready[g] = 1'b1;
    checkOutput("model_req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_out_v));
    if (m_out_v) begin
      checkOutput("model_rsp_id", 32'(bus.rsp_id), 32'(m_out_id));
      checkOutput("model_rsp_value", 32'(bus.rsp_value), 32'(m_out_val));
    end
    if (m_s1_v) checkOutput("model_lut_idx", 32'(lut_idx), 32'(m_s1_idx));
    if (adv) begin
      m_out_v = m_s1_v;
      if (m_s1_v) begin m_out_id = m_s1_id; m_out_val = m_s1_val; end
      m_s1_v = fnd;
      if (fnd) begin
        a        = bus.req_atten[g*12 +: 12];
        m_s1_id  = g;
        m_s1_idx = a[7:0];
        m_s1_val = expectVal(a, bus.req_sign[g]);
        m_rr     = g;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    monitor();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [11:0] atten, input logic sign);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_atten[id*12 +: 12] = atten;
    bus.req_sign[id] = sign;
  endtask

  task automatic allValid();
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_atten[i*12 +: 12] = {4'(i), 8'(i * 64 + 5)};
      bus.req_sign[i] = i[0];
    end
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    real r;
    for (int i = 0; i < 256; i++) begin
      r = ((2.0 ** ((255.0 - real'(i)) / 256.0)) - 1.0) * 1024.0;
      lut[i] = 10'($rtoi(r + 0.5));
    end

    vecs[0] = '{0, 12'h000, 1'b0, 12'h7FA};
    vecs[1] = '{2, 12'h080, 1'b1, 12'hA5C};
    vecs[2] = '{1, 12'h1FF, 1'b0, 12'h200};
    vecs[3] = '{3, 12'hB00, 1'b1, 12'h000};
    vecs[4] = '{0, 12'h0FF, 1'b1, 12'hC00};
    vecs[5] = '{1, 12'hA00, 1'b0, 12'h001};
    vecs[6] = '{2, 12'h380, 1'b0, 12'h0B4};
    vecs[7] = '{3, 12'hF80, 1'b1, 12'h000};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_atten = '0;
    bus.req_sign  = '0;
    bus.rsp_ready = 1'b1;
    m_rr = NREQ - 1; m_s1_v = 0; m_out_v = 0;
    m_s1_id = 0; m_s1_val = '0; m_s1_idx = '0; m_out_id = 0; m_out_val = '0;

    // Reset values
    nextCycle();
    settle();
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    checkOutput("reset_rsp_value", 32'(bus.rsp_value), 32'h0);
    checkOutput("reset_lut_idx", 32'(lut_idx), 32'h0);
    nextCycle();
    reset = 1'b0;

    // Single-request vectors with fixed two-cycle latency
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].id, vecs[v].atten, vecs[v].sign);
      settle();
      checkOutput("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[v].id));
      nextCycle();
      bus.req_valid = '0;
      settle();
      checkOutput("vec_latency", 32'(bus.rsp_valid), 32'h0);
      nextCycle();
      settle();
      checkOutput("vec_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("vec_rsp_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      checkOutput("vec_rsp_value", 32'(bus.rsp_value), 32'(vecs[v].exp_value));
      nextCycle();
    end

    // All requesters valid after reset: strict rotation from requester 0
    reset = 1'b1;
    settle();
    nextCycle();
    reset = 1'b0;
    allValid();
    for (int c = 0; c < 8; c++) begin
      settle();
      checkOutput("rotation_grant", 32'(bus.req_ready), 32'(1 << (c % NREQ)));
      nextCycle();
    end

    // Backpressure mid-stream
    bus.rsp_ready = 1'b0;
    repeat (5) begin
      settle();
      checkOutput("stall_req_ready", 32'(bus.req_ready), 32'h0);
      nextCycle();
    end
    bus.rsp_ready = 1'b1;
    repeat (8) begin
      settle();
      nextCycle();
    end

    // Reset with two entries in flight
    reset = 1'b1;
    #1;
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("midreset_lut_idx", 32'(lut_idx), 32'h0);
    settle();
    nextCycle();
    reset = 1'b0;
    settle();
    checkOutput("postreset_grant", 32'(bus.req_ready), 32'h1);
    checkOutput("postreset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    nextCycle();
    settle();
    checkOutput("postreset_no_stale", 32'(bus.rsp_valid), 32'h0);
    nextCycle();

    // Random traffic; requesters hold their request until granted
    bus.req_valid = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      settle();
      acc = bus.req_valid & bus.req_ready;
      nextCycle();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 60);
          bus.req_atten[i*12 +: 12] = 12'($urandom_range(0, 4095));
          bus.req_sign[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 99) < 75);
    end

    // Drain
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) begin
      settle();
      nextCycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
